// File: rtl/pmix_pkg.sv
// Shared definitions for the phase-mixer rotator: default parameters, the
// slew FSM state type and the modular phase arithmetic helpers used by both
// the slew controller and the tap-select logic.
package pmix_pkg;

   localparam int DEF_NUM_PHASES = 360;
   localparam int DEF_CODE_W     = 9;
   localparam int DEF_NUM_CH     = 2;
   localparam int DEF_SLEW_DIV   = 1;

   typedef enum logic {
      IDLE = 1'b0,
      SLEW = 1'b1
   } slew_state_t;

   // (a + b) mod n for operands already in [0, n). Evaluated on int so the
   // intermediate sum never overflows the code width.
   function automatic int phase_add(input int a, input int b, input int n);
      int s;
      s = a + b;
      if (s >= n) begin
         s = s - n;
      end
      return s;
   endfunction

   // Direction of the shortest move from cur to tgt on an n-point circle:
   // +1 to increment, -1 to decrement. The half-circle tie increments.
   function automatic int phase_dir(input int cur, input int tgt, input int n);
      int d;
      d = tgt - cur;
      if (d < 0) begin
         d = d + n;
      end
      return (d <= n / 2) ? 1 : -1;
   endfunction

endpackage

// File: rtl/pmix_slew_ctrl.sv
// Slew controller: accepts a target phase code over a valid/ready handshake,
// flags out-of-range codes, and walks code_cur one step at a time toward the
// target along the shortest path around the phase circle.
//
// Handshake: a target transfers on a clk edge where code_valid && code_ready.
// code_ready is high exactly while the FSM is IDLE; offers made while busy are
// dropped, not queued. An out-of-range code still transfers (it is consumed)
// but leaves the target untouched and raises code_err for one cycle.
//
// Build option PMIX_GLITCH_GUARD_EN: when defined, a due step is held off
// until the top level reports (step_ok) that the current and next selected
// taps carry the same level, so a step can never shorten an output pulse.
module pmix_slew_ctrl
   import pmix_pkg::*;
#(
   parameter int NUM_PHASES = DEF_NUM_PHASES,
   parameter int CODE_W     = DEF_CODE_W,
   parameter int SLEW_DIV   = DEF_SLEW_DIV
) (
   input  logic              clk,
   input  logic              rst_n,
`ifdef PMIX_GLITCH_GUARD_EN
   input  logic              step_ok,
   output logic [CODE_W-1:0] code_step,
`endif
   input  logic [CODE_W-1:0] code,
   input  logic              code_valid,
   output logic              code_ready,
   output logic              code_err,
   output logic [CODE_W-1:0] code_cur,
   output logic              busy,
   output logic              state_dbg
);

   localparam int CNT_W = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLEW_DIV - 1);

   slew_state_t       state_q, state_d;
   logic [CODE_W-1:0] target_q, target_d;
   logic [CODE_W-1:0] cur_q, cur_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CODE_W-1:0] step_code;
   logic              err_q, err_d;
   logic              accept;
   logic              in_range;
   logic              guard_pass;

   assign code_ready = (state_q == IDLE);
   assign busy       = (state_q == SLEW);
   assign code_cur   = cur_q;
   assign code_err   = err_q;
   assign state_dbg  = state_q;

   assign accept   = code_valid && code_ready;
   assign in_range = ({1'b0, code} < (CODE_W + 1)'(NUM_PHASES));
   assign err_d    = accept && !in_range;

`ifdef PMIX_GLITCH_GUARD_EN
   assign code_step  = step_code;
   assign guard_pass = step_ok;
`else
   assign guard_pass = 1'b1;
`endif

   // The code code_cur would take on the next step: one position toward the
   // target along the shorter arc, wrapping at both ends of the circle.
   always_comb begin
      step_code = cur_q;
      if (phase_dir(int'(cur_q), int'(target_q), NUM_PHASES) > 0) begin
         step_code = CODE_W'(phase_add(int'(cur_q), 1, NUM_PHASES));
      end else begin
         step_code = CODE_W'(phase_add(int'(cur_q), NUM_PHASES - 1, NUM_PHASES));
      end
   end

   // Next-state logic: accept targets in IDLE, pace steps with the divider in
   // SLEW, and drop back to IDLE on the step that lands on the target.
   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      cur_d    = cur_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept && in_range) begin
               target_d = code;
               if (code != cur_q) begin
                  state_d = SLEW;
                  cnt_d   = '0;
               end
            end
         end
         SLEW: begin
            if (cnt_q == CNT_LAST) begin
               // A due step that the guard blocks keeps the counter parked at
               // its last value so the step retries on the following cycle.
               if (guard_pass) begin
                  cur_d = step_code;
                  cnt_d = '0;
                  if (step_code == target_q) begin
                     state_d = IDLE;
                  end
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register; reset abandons any target in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         target_q <= '0;
         cur_q    <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         cur_q    <= cur_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: rtl/pmix_phase_rotator.sv
// Phase rotator top level: oversamples clk_in through a NUM_PHASES-deep tap
// line clocked by clk and drives NUM_CH equally spaced phase outputs, each a
// registered pick of one tap. The pick follows code_cur from the slew
// controller, so all channels rotate together one tap per step.
//
// Latency from a clk_in change to pmix_clk[k] is sel_k + 2 clk cycles: one to
// sample into tap[0], sel_k to reach the selected tap, one output register.
//
// Build option PMIX_GLITCH_GUARD_EN: when defined, the rotator only lets the
// controller step when the current and next channel-0 taps are equal.
module pmix_phase_rotator
   import pmix_pkg::*;
#(
   parameter int NUM_PHASES = DEF_NUM_PHASES,
   parameter int CODE_W     = DEF_CODE_W,
   parameter int NUM_CH     = DEF_NUM_CH,
   parameter int SLEW_DIV   = DEF_SLEW_DIV
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clk_in,
   input  logic [CODE_W-1:0] code,
   input  logic              code_valid,
   output logic              code_ready,
   output logic              code_err,
   output logic [CODE_W-1:0] code_cur,
   output logic              busy,
   output logic [NUM_CH-1:0] pmix_clk,
   output logic [NUM_CH-1:0] pmix_clk_n,
   output logic              slew_state
);

   localparam int SPACING = NUM_PHASES / NUM_CH;

   logic [NUM_PHASES-1:0] tap_q;
   logic [CODE_W-1:0]     sel [NUM_CH];
   logic [NUM_CH-1:0]     pmix_q;

`ifdef PMIX_GLITCH_GUARD_EN
   logic [CODE_W-1:0] code_step;
   logic              step_ok;

   // A step is harmless when both taps it moves between hold the same level.
   assign step_ok = (tap_q[sel[0]] == tap_q[code_step]);
`endif

   pmix_slew_ctrl #(
      .NUM_PHASES (NUM_PHASES),
      .CODE_W     (CODE_W),
      .SLEW_DIV   (SLEW_DIV)
   ) u_slew_ctrl (
      .clk        (clk),
      .rst_n      (rst_n),
`ifdef PMIX_GLITCH_GUARD_EN
      .step_ok    (step_ok),
      .code_step  (code_step),
`endif
      .code       (code),
      .code_valid (code_valid),
      .code_ready (code_ready),
      .code_err   (code_err),
      .code_cur   (code_cur),
      .busy       (busy),
      .state_dbg  (slew_state)
   );

   // Tap line: tap[0] samples clk_in, every later tap is one clk older.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tap_q <= '0;
      end else begin
         tap_q <= {tap_q[NUM_PHASES-2:0], clk_in};
      end
   end

   // Per-channel tap index: code_cur plus the fixed channel offset, modulo
   // the circle length.
   always_comb begin
      for (int k = 0; k < NUM_CH; k++) begin
         sel[k] = CODE_W'(phase_add(int'(code_cur), k * SPACING, NUM_PHASES));
      end
   end

   // Output registers: each channel re-times its selected tap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pmix_q <= '0;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            pmix_q[k] <= tap_q[sel[k]];
         end
      end
   end

   assign pmix_clk   = pmix_q;
   assign pmix_clk_n = ~pmix_q;

endmodule

// File: tb/tb_pmix_phase_rotator.sv
module tb_pmix_phase_rotator;

  localparam int N   = 360;
  localparam int CW  = 9;
  localparam int NCH = 2;
  localparam int SD  = 4;
  localparam int SP  = N / NCH;
  localparam int ALL_ONES = (1 << NCH) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic clk_in;
  logic [CW-1:0] code;
  logic code_valid;
  logic code_ready;
  logic code_err;
  logic [CW-1:0] code_cur;
  logic busy;
  logic [NCH-1:0] pmix_clk;
  logic [NCH-1:0] pmix_clk_n;
  logic slew_state;

  always #5 clk = ~clk;

  pmix_phase_rotator #(
    .NUM_PHASES (N),
    .CODE_W     (CW),
    .NUM_CH     (NCH),
    .SLEW_DIV   (SD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_in     (clk_in),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .code_err   (code_err),
    .code_cur   (code_cur),
    .busy       (busy),
    .pmix_clk   (pmix_clk),
    .pmix_clk_n (pmix_clk_n),
    .slew_state (slew_state)
  );

  // ---------------- scoreboard state ----------------
  typedef struct {
    int code;
    int edge_no;
  } step_t;

  step_t exp_q[$];     // expected code_cur values and the edge each appears
  int    err_q[$];     // edges after which code_err must be high
  bit    tapm[$];      // reference delay line, tapm[0] newest sample
  int    cyc = 0;      // number of rising edges so far
  int    acc_edge = 0; // edge at which the last accepted target transferred
  int    mcode = 0;    // code in force before the coming edge
  int    last_seen = 0;
  int    m_target = 0; // code the rotator settles on once all steps are done
  int    half_per = 20;
  logic [NCH-1:0] exp_pmix = '0;
  int    errors = 0;
  int    checks = 0;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, want, cyc);
    end
  endtask

  // ---------------- reference delay line ----------------
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_pmix = '0;
      foreach (tapm[i]) tapm[i] = 1'b0;
    end else begin
      for (int k = 0; k < NCH; k++) exp_pmix[k] = tapm[(mcode + k * SP) % N];
      tapm.push_front(clk_in);
      void'(tapm.pop_back());
    end
  end

  // ---------------- monitor ----------------
  step_t e;
  logic [NCH-1:0] inv_pmix;
  bit exp_busy;
  bit exp_err;
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_code_cur", int'(code_cur), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_ready", int'(code_ready), 1);
      check("rst_err", int'(code_err), 0);
      check("rst_pmix", int'(pmix_clk), 0);
      check("rst_pmix_n", int'(pmix_clk_n), ALL_ONES);
    end else begin
      if (int'(code_cur) != last_seen) begin
        if (exp_q.size() == 0) begin
          check("unexpected_step", int'(code_cur), last_seen);
        end else begin
          e = exp_q.pop_front();
          check("step_code", int'(code_cur), e.code);
`ifdef PMIX_GLITCH_GUARD_EN
          check("step_not_early", int'(cyc >= e.edge_no), 1);
`else
          check("step_edge", cyc, e.edge_no);
`endif
          mcode = e.code;
        end
        last_seen = int'(code_cur);
      end
      exp_busy = (exp_q.size() != 0) && (cyc >= acc_edge);
      check("busy", int'(busy), int'(exp_busy));
      check("code_ready", int'(code_ready), int'(!exp_busy));
      check("slew_state", int'(slew_state), int'(exp_busy));
      while (err_q.size() != 0 && err_q[0] < cyc) begin
        check("err_missed", 0, 1);
        void'(err_q.pop_front());
      end
      exp_err = (err_q.size() != 0) && (err_q[0] == cyc);
      if (exp_err) void'(err_q.pop_front());
      check("code_err", int'(code_err), int'(exp_err));
      inv_pmix = ~exp_pmix;
      check("pmix_clk", int'(pmix_clk), int'(exp_pmix));
      check("pmix_clk_n", int'(pmix_clk_n), int'(inv_pmix));
    end
  end

  // ---------------- clk_in stimulus ----------------
  initial begin
    clk_in = 1'b0;
    forever begin
      int h;
      h = (half_per > 0) ? half_per : int'($urandom_range(2, 30));
      repeat (h) @(posedge clk);
      #1 clk_in = ~clk_in;
    end
  end

  // ---------------- driver tasks ----------------
  // Offer one target for one cycle. If no step is outstanding the rotator is
  // idle at the sampling edge, so the offer transfers there.
  task automatic offer(input int v);
    int c;
    int d;
    @(posedge clk);
    #1;
    code = CW'(v);
    code_valid = 1'b1;
    if (exp_q.size() == 0) begin
      acc_edge = cyc + 1;
      if (v >= N) begin
        err_q.push_back(cyc + 1);
      end else begin
        c = m_target;
        for (int i = 1; c != v; i++) begin
          d = (v - c + N) % N;
          if (d <= N / 2) c = (c + 1) % N;
          else c = (c + N - 1) % N;
          exp_q.push_back('{code: c, edge_no: acc_edge + SD * i});
        end
        m_target = v;
      end
    end
    @(posedge clk);
    #1;
    code_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    check("slew_done_in_time", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic assert_reset(input bit check_now);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    err_q.delete();
    mcode = 0;
    last_seen = 0;
    m_target = 0;
    if (check_now) begin
      #1;
      check("async_rst_code_cur", int'(code_cur), 0);
      check("async_rst_busy", int'(busy), 0);
      check("async_rst_ready", int'(code_ready), 1);
      check("async_rst_pmix", int'(pmix_clk), 0);
      check("async_rst_pmix_n", int'(pmix_clk_n), ALL_ONES);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    code_valid = 1'b0;
    code = '0;
    for (int i = 0; i < N; i++) tapm.push_back(1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Code 0: channel 0 two cycles late, channel 1 half a circle further.
    repeat (400) @(posedge clk);

    offer(10);
    wait_idle();
    repeat (60) @(posedge clk);

    // Decrement across the zero wrap, then increment, then the tie.
    offer(5);
    wait_idle();
    offer(350);
    wait_idle();
    offer(0);
    wait_idle();
    offer(180);
    wait_idle();
    repeat (10) @(posedge clk);

    // Out-of-range codes, an offer while busy, and a same-code offer.
    offer(400);
    repeat (3) @(posedge clk);
    offer(511);
    repeat (3) @(posedge clk);
    offer(200);
    repeat (6) @(posedge clk);
    offer(20);
    wait_idle();
    offer(200);
    repeat (8) @(posedge clk);

    // Random targets and random clk_in half-periods.
    half_per = 0;
    for (int i = 0; i < 10; i++) begin
      offer(int'($urandom_range(0, 511)));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 6)) @(posedge clk);
        offer(int'($urandom_range(0, 359)));
      end
      wait_idle();
      repeat ($urandom_range(1, 40)) @(posedge clk);
    end

    // Reset in the middle of a 0 -> 100 slew.
    half_per = 20;
    assert_reset(1'b0);
    repeat (5) @(posedge clk);
    offer(100);
    repeat (150) @(posedge clk);
    assert_reset(1'b1);
    repeat (5) @(posedge clk);
    offer(7);
    wait_idle();
    repeat (30) @(posedge clk);

    check("steps_left", exp_q.size(), 0);
    check("errs_left", err_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
